// File: rtl/ps2_frame_rx.sv
// PS/2 device-to-host frame receiver with a receive FIFO and ready/nextdata_n pop interface.
// Optional macro PS2_PARITY_CHECK_EN enables odd-parity validation of received frames.
module ps2_frame_rx #(
    parameter int unsigned FIFO_AW     = 3,
    parameter int unsigned TIMEOUT_CYC = 50000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_data,
    input  logic       nextdata_n,
    output logic [7:0] data,
    output logic       ready,
    output logic       overflow,
    output logic       frame_err
);
    localparam int unsigned DEPTH = 2 ** FIFO_AW;
    localparam int unsigned TW    = $clog2(TIMEOUT_CYC + 1);

    logic [2:0]          ck_s, d_s;
    logic                fall, sd;
    logic [9:0]          sr;
    logic [10:0]         frame_next;
    logic [3:0]          bitcnt;
    logic [TW-1:0]       tcnt;
    logic                frame_done, par_ok, valid, wr;
    logic [7:0]          mem [DEPTH];
    logic [FIFO_AW-1:0]  wp, rp;
    logic [FIFO_AW:0]    cnt;
    logic                full, pop, wr_ok, drop;

    // Reset to 1 (idle bus) so releasing reset cannot look like a falling edge
    always_ff @(posedge clk) begin
        if (rst) begin
            ck_s <= '1;
            d_s  <= '1;
        end else begin
            ck_s <= {ck_s[1:0], ps2_clk};
            d_s  <= {d_s[1:0], ps2_data};
        end
    end

    assign fall = ck_s[2] & ~ck_s[1];
    assign sd   = d_s[1];

    always_comb begin
        frame_next = {sd, sr};
        frame_done = fall && (bitcnt == 4'd10);
`ifdef PS2_PARITY_CHECK_EN
        par_ok     = ^frame_next[9:1];
`else
        par_ok     = 1'b1;
`endif
        valid      = ~frame_next[0] & frame_next[10] & par_ok;
        wr         = frame_done & valid;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sr        <= '0;
            bitcnt    <= '0;
            tcnt      <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= frame_done & ~valid;
            if (fall) begin
                sr     <= frame_next[10:1];
                tcnt   <= '0;
                bitcnt <= (bitcnt == 4'd10) ? 4'd0 : bitcnt + 4'd1;
            end else if (bitcnt != 4'd0) begin
                // Stalled partial frame is dropped without flagging an error
                if (tcnt == TW'(TIMEOUT_CYC)) begin
                    bitcnt <= '0;
                    tcnt   <= '0;
                end else begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    assign full  = (cnt == (FIFO_AW+1)'(DEPTH));
    assign ready = (cnt != '0);
    assign pop   = ready & ~nextdata_n;
    assign wr_ok = wr & (~full | pop);
    assign drop  = wr & full & ~pop;
    assign data  = mem[rp];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= '0;
            wp       <= '0;
            rp       <= '0;
            cnt      <= '0;
            overflow <= 1'b0;
        end else begin
            if (wr_ok) begin
                mem[wp] <= frame_next[8:1];
                wp      <= wp + 1'b1;
            end
            if (pop) rp <= rp + 1'b1;
            case ({wr_ok, pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
            if (drop)     overflow <= 1'b1;
            else if (pop) overflow <= 1'b0;
        end
    end
endmodule

// File: tb/tb_ps2_frame_rx.sv
// Directed bench for ps2_frame_rx: framing, FIFO order/overflow, parity, timeout, reset mid-frame.
module tb_ps2_frame_rx;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       ps2_clk = 1'b1;
    logic       ps2_data = 1'b1;
    logic       nextdata_n = 1'b1;
    logic [7:0] data;
    logic       ready, overflow, frame_err;

    int vectors = 0;
    int miscompares = 0;
    int errcnt = 0;
    int err0;

    ps2_frame_rx #(.FIFO_AW(3), .TIMEOUT_CYC(200)) dut (
        .clk(clk), .rst(rst), .ps2_clk(ps2_clk), .ps2_data(ps2_data),
        .nextdata_n(nextdata_n), .data(data), .ready(ready),
        .overflow(overflow), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (frame_err === 1'b1) errcnt <= errcnt + 1;

    task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Sends the first nbits of a frame for byte b; flip inverts the correct odd parity bit
    task automatic send_bits(input logic [7:0] b, input logic flip, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            repeat (10) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (20) @(negedge clk);
            ps2_clk = 1'b1;
            repeat (10) @(negedge clk);
        end
        ps2_data = 1'b1;
    endtask

    task automatic pop1;
        nextdata_n = 1'b0;
        @(negedge clk);
        nextdata_n = 1'b1;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_overflow", overflow, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_data", data, 0);

        // Popping an empty FIFO is ignored
        pop1();
        check("empty_pop_ready", ready, 0);

        send_bits(8'h1C, 1'b0, 11);
        check("single_ready", ready, 1);
        check("single_data", data, 9'h1C);
        check("single_overflow", overflow, 0);
        pop1();
        check("single_pop_ready", ready, 0);

        send_bits(8'h1C, 1'b0, 11);
        send_bits(8'hF0, 1'b0, 11);
        send_bits(8'h1C, 1'b0, 11);
        check("seq_data0", data, 9'h1C);
        pop1();
        check("seq_data1", data, 9'hF0);
        pop1();
        check("seq_data2", data, 9'h1C);
        check("seq_ready2", ready, 1);
        pop1();
        check("seq_ready_end", ready, 0);

        for (int i = 0; i < 9; i++) send_bits(8'h10 + 8'(i), 1'b0, 11);
        check("ovf_flag", overflow, 1);
        check("ovf_head", data, 9'h10);
        pop1();
        check("ovf_cleared", overflow, 0);
        check("ovf_second", data, 9'h11);
        // Back-to-back pops, one byte per cycle
        nextdata_n = 1'b0;
        for (int i = 1; i < 8; i++) begin
            check("drain_data", data, 9'h10 + 9'(i));
            @(negedge clk);
        end
        nextdata_n = 1'b1;
        check("drain_ready", ready, 0);
        check("drain_overflow", overflow, 0);

        err0 = errcnt;
        send_bits(8'h1C, 1'b1, 11);
`ifdef PS2_PARITY_CHECK_EN
        check("par_err_pulses", 9'(errcnt - err0), 1);
        check("par_ready", ready, 0);
`else
        check("par_err_pulses", 9'(errcnt - err0), 0);
        check("par_ready", ready, 1);
        check("par_data", data, 9'h1C);
        pop1();
`endif

        err0 = errcnt;
        send_bits(8'hFF, 1'b0, 5);
        repeat (300) @(negedge clk);
        send_bits(8'h5A, 1'b0, 11);
        check("tmo_ready", ready, 1);
        check("tmo_data", data, 9'h5A);
        check("tmo_no_err", 9'(errcnt - err0), 0);
        pop1();
        check("tmo_single", ready, 0);

        send_bits(8'h11, 1'b0, 11);
        send_bits(8'h22, 1'b0, 11);
        check("rst_pre_ready", ready, 1);
        send_bits(8'h33, 1'b0, 6);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", ready, 0);
        check("rst_mid_overflow", overflow, 0);
        check("rst_mid_data", data, 0);
        send_bits(8'h29, 1'b0, 11);
        check("post_rst_ready", ready, 1);
        check("post_rst_data", data, 9'h29);
        pop1();
        check("post_rst_empty", ready, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
